linear_layer_start_fifo_srl_reader: RTL and testbench
=====================================================

LINEAR_LAYER_START_FIFO_SRL_READER -- requirements
Module: linear_layer_start_fifo_srl_reader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 1: token width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 3: shift-register tap address width.
REQ-003 The block SHALL have parameter DEPTH, default 7: shift-register entries, DEPTH <= 2^ADDR_WIDTH.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 if_write_ce  input  1  write-side clock enable.
REQ-007 if_write  input  1  write request.
REQ-008 if_din  input  DATA_WIDTH  write data.
REQ-009 if_full_n  output  1  high when the block can accept a write.
REQ-010 if_read_ce  input  1  read-side clock enable.
REQ-011 if_read  input  1  read request (consumer pop).
REQ-012 if_dout  output  DATA_WIDTH  registered oldest token.
REQ-013 if_empty_n  output  1  high when if_dout holds a valid token.

Function
REQ-014 Storage SHALL be a DEPTH-entry shift register: on push, entry 0 takes if_din and entry i+1 takes entry i; the tap is selected by an ADDR_WIDTH-bit read address.
REQ-015 Push SHALL occur when if_write && if_write_ce && if_full_n; pop SHALL occur when if_read && if_read_ce && if_empty_n.
REQ-016 An occupancy counter cnt (0..DEPTH) SHALL count tokens in the shift register; read address = cnt-1 (oldest token).
REQ-017 The output stage SHALL be one register (dout_reg, valid bit out_vld) in front of the shift register; if_dout = dout_reg, if_empty_n = out_vld.
REQ-018 Load SHALL occur when cnt > 0 and (out_vld == 0 or pop): dout_reg <= tap[cnt-1], out_vld <= 1.
REQ-019 When pop occurs without load, out_vld SHALL go to 0 on the next cycle.
REQ-020 cnt update: push and no load -> +1; load and no push -> -1; both or neither -> unchanged.
REQ-021 On simultaneous push and load, the tap SHALL be read from pre-shift contents at address cnt-1, so ordering is preserved.
REQ-022 if_full_n SHALL be registered-equivalent: high iff cnt < DEPTH; total capacity is DEPTH+1 tokens.
REQ-023 Push while full SHALL be ignored (no shift, no count change); pop while empty SHALL be ignored.
REQ-024 There SHALL be no din-to-dout bypass: a token pushed at edge N into an empty block is visible on if_dout with if_empty_n=1 after edge N+1.
REQ-025 Read-side state machine: EMPTY (out_vld=0) -> VALID on load; VALID -> VALID on pop with load or no pop; VALID -> EMPTY on pop with cnt == 0.
REQ-026 cnt SHALL never wrap: no increment beyond DEPTH, no decrement below 0.
REQ-027 Tokens SHALL leave in strict arrival order with no loss or duplication.

Reset
REQ-028 On reset high at a clock edge: cnt=0, out_vld=0, dout_reg=0, if_full_n=1, if_empty_n=0; shift-register contents need not be cleared.
REQ-029 Reset SHALL override simultaneous push/pop in the same cycle; asserted mid-operation, it SHALL discard all held tokens.
REQ-030 The first push SHALL be accepted on the first edge after reset deassertion.

Verification
REQ-031 Single token: reset, push 1 at edge 0, no reads -> if_empty_n=1, if_dout=1 after edge 1; pop at edge 2 -> if_empty_n=0 after edge 2.
REQ-032 Fill (DEPTH=7, DATA_WIDTH=4): back-to-back push 0..7, no reads -> if_full_n=0 after the 8th push, if_dout=0; 9th push ignored; then 8 pops return 0..7 in order.
REQ-033 Streaming: push and pop asserted every cycle for 20 cycles after first valid -> if_dout sequence monotonic 0,1,2,..., cnt constant, if_full_n stays 1.
REQ-034 Full plus simultaneous pop and push: at full, pop+push same cycle -> both accepted, if_full_n stays 0, new token last out.
REQ-035 CE gating: if_write=1 with if_write_ce=0, if_read=1 with if_read_ce=0 -> no state change.
REQ-036 Reset mid-operation with 4 tokens held -> next cycle if_empty_n=0, if_full_n=1; next push/pop sequence returns only post-reset tokens.

Source files
------------

// File: rtl/linear_layer_start_fifo_srl_reader.sv
// FIFO built from a DEPTH-entry shift register with a registered output stage.
// Total capacity is DEPTH+1 tokens: DEPTH held in the shift register plus one in dout_reg.
module linear_layer_start_fifo_srl_reader #(
   parameter int DATA_WIDTH = 1,
   parameter int ADDR_WIDTH = 3,
   parameter int DEPTH      = 7
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  if_write_ce,
   input  logic                  if_write,
   input  logic [DATA_WIDTH-1:0] if_din,
   output logic                  if_full_n,
   input  logic                  if_read_ce,
   input  logic                  if_read,
   output logic [DATA_WIDTH-1:0] if_dout,
   output logic                  if_empty_n
);

   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

   typedef enum logic {EMPTY = 1'b0, VALID = 1'b1} state_t;

   state_t                  state, state_next;
   logic [DATA_WIDTH-1:0]   sr [DEPTH];
   logic [ADDR_WIDTH:0]     cnt;
   logic [ADDR_WIDTH-1:0]   raddr;
   logic [DATA_WIDTH-1:0]   tap;
   logic [DATA_WIDTH-1:0]   dout_reg;
   logic                    out_vld;
   logic                    push, pop, load;

   assign if_full_n = (cnt < DEPTH_C);
   assign pop       = if_read && if_read_ce && out_vld;
   assign load      = (cnt != '0) && (!out_vld || pop);
   // A pop at full moves the oldest tap out in the same cycle, so a concurrent push fits.
   assign push      = if_write && if_write_ce && (if_full_n || load);
   assign raddr     = ADDR_WIDTH'(cnt - 1'b1);

   always_comb begin
      tap = '0;
      for (int i = 0; i < DEPTH; i++)
         if (raddr == ADDR_WIDTH'(i)) tap = sr[i];
   end

   always_ff @(posedge clk) begin
      if (push) begin
         sr[0] <= if_din;
         for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt      <= '0;
         dout_reg <= '0;
      end else begin
         if (push && !load)      cnt <= cnt + 1'b1;
         else if (load && !push) cnt <= cnt - 1'b1;
         if (load) dout_reg <= tap;
      end
   end

   // Read-side state machine: state register, next-state logic, outputs.
   always_ff @(posedge clk) begin
      if (reset) state <= EMPTY;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         EMPTY:   if (load) state_next = VALID;
         VALID:   if (pop && !load) state_next = EMPTY;
         default: state_next = EMPTY;
      endcase
   end

   always_comb begin
      out_vld = (state == VALID);
   end

   assign if_dout    = dout_reg;
   assign if_empty_n = out_vld;

endmodule

// File: tb/tb_linear_layer_start_fifo_srl_reader.sv
// Directed bench for linear_layer_start_fifo_srl_reader (DEPTH=7, DATA_WIDTH=4).
module tb_linear_layer_start_fifo_srl_reader;

   logic       clk = 1'b0;
   logic       reset, if_write_ce, if_write, if_read_ce, if_read;
   logic [3:0] if_din;
   logic       if_full_n, if_empty_n;
   logic [3:0] if_dout;
   int         n_total = 0;
   int         n_pass  = 0;

   linear_layer_start_fifo_srl_reader #(
      .DATA_WIDTH(4), .ADDR_WIDTH(3), .DEPTH(7)
   ) dut (
      .clk(clk), .reset(reset),
      .if_write_ce(if_write_ce), .if_write(if_write), .if_din(if_din),
      .if_full_n(if_full_n),
      .if_read_ce(if_read_ce), .if_read(if_read),
      .if_dout(if_dout), .if_empty_n(if_empty_n)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst, wce, w;
      logic [3:0] din;
      logic       rce, r;
      logic       full_n, empty_n;
      logic [3:0] dout;
   } vec_t;

   vec_t vt[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic cyc(input logic rst, input logic wce, input logic w, input logic [3:0] din,
                      input logic rce, input logic r);
      reset = rst; if_write_ce = wce; if_write = w; if_din = din;
      if_read_ce = rce; if_read = r;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();  cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0); endtask
   task automatic do_idle();   cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0); endtask
   task automatic do_push(input logic [3:0] d); cyc(1'b0, 1'b1, 1'b1, d, 1'b0, 1'b0); endtask
   task automatic do_pop();    cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1); endtask
   task automatic do_both(input logic [3:0] d); cyc(1'b0, 1'b1, 1'b1, d, 1'b1, 1'b1); endtask

   initial begin
      reset = 1'b1; if_write_ce = 1'b0; if_write = 1'b0; if_din = '0;
      if_read_ce = 1'b0; if_read = 1'b0;

      //          rst   wce   w     din    rce   r     full  empty dout
      vt[0]  = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
      vt[1]  = '{1'b1, 1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0};
      vt[2]  = '{1'b0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
      vt[3]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1};
      vt[4]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1};
      vt[5]  = '{1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1};
      vt[6]  = '{1'b0, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1};
      vt[7]  = '{1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b1, 1'b1, 1'b1, 4'd2};
      vt[8]  = '{1'b0, 1'b0, 1'b1, 4'd7, 1'b1, 1'b1, 1'b1, 1'b1, 4'd3};
      vt[9]  = '{1'b0, 1'b1, 1'b1, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0, 4'd3};
      vt[10] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd4};
      vt[11] = '{1'b1, 1'b1, 1'b1, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};

      for (int i = 0; i < 12; i++) begin
         cyc(vt[i].rst, vt[i].wce, vt[i].w, vt[i].din, vt[i].rce, vt[i].r);
         chk($sformatf("vec%0d full_n", i),  32'(if_full_n),  32'(vt[i].full_n));
         chk($sformatf("vec%0d empty_n", i), 32'(if_empty_n), 32'(vt[i].empty_n));
         chk($sformatf("vec%0d dout", i),    32'(if_dout),    32'(vt[i].dout));
      end

      // Fill to capacity, overflow push ignored, drain in order.
      do_reset();
      for (int k = 0; k < 8; k++) do_push(4'(k));
      chk("fill full_n", 32'(if_full_n), 32'd0);
      chk("fill empty_n", 32'(if_empty_n), 32'd1);
      chk("fill dout", 32'(if_dout), 32'd0);
      do_push(4'd8);
      chk("overflow full_n", 32'(if_full_n), 32'd0);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("drain%0d empty_n", k), 32'(if_empty_n), 32'd1);
         chk($sformatf("drain%0d dout", k), 32'(if_dout), 32'(k));
         do_pop();
         if (k == 0) chk("drain full_n", 32'(if_full_n), 32'd1);
      end
      chk("drained empty_n", 32'(if_empty_n), 32'd0);

      // Simultaneous pop and push at full.
      do_reset();
      for (int k = 0; k < 8; k++) do_push(4'(k));
      do_both(4'd9);
      chk("fullboth full_n", 32'(if_full_n), 32'd0);
      chk("fullboth dout", 32'(if_dout), 32'd1);
      for (int k = 1; k < 9; k++) begin
         chk($sformatf("fb_drain%0d dout", k), 32'(if_dout), (k == 8) ? 32'd9 : 32'(k));
         do_pop();
      end
      chk("fb_drained empty_n", 32'(if_empty_n), 32'd0);

      // Streaming: push and pop every cycle.
      do_reset();
      do_push(4'd0);
      do_push(4'd1);
      chk("stream first dout", 32'(if_dout), 32'd0);
      for (int k = 0; k < 20; k++) begin
         do_both(4'(k + 2));
         chk($sformatf("stream%0d dout", k), 32'(if_dout), 32'((k + 1) % 16));
         chk($sformatf("stream%0d full_n", k), 32'(if_full_n), 32'd1);
         chk($sformatf("stream%0d empty_n", k), 32'(if_empty_n), 32'd1);
      end

      // Reset with tokens held discards them all.
      do_reset();
      for (int k = 0; k < 4; k++) do_push(4'(k + 5));
      do_reset();
      chk("midrst empty_n", 32'(if_empty_n), 32'd0);
      chk("midrst full_n", 32'(if_full_n), 32'd1);
      chk("midrst dout", 32'(if_dout), 32'd0);
      do_push(4'd11);
      do_idle();
      chk("postrst empty_n", 32'(if_empty_n), 32'd1);
      chk("postrst dout", 32'(if_dout), 32'd11);
      do_pop();
      chk("postrst drained", 32'(if_empty_n), 32'd0);
      do_idle();
      chk("postrst no stale", 32'(if_empty_n), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
